// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: FSM state encoding and coin values.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  // Coin values in nickels.
  localparam int NICKEL  = 1;
  localparam int DIME    = 2;
  localparam int QUARTER = 5;

endpackage

// File: rtl/vend_change.sv
// Change sequencer: after a load, emits one pulse per nickel, each pulse followed by a one-cycle gap.
module vend_change #(
  parameter int CW = 4
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_count,
  output logic          pulse,
  output logic          step,
  output logic          done
);

  logic [CW-1:0] remaining;

  // step marks the edge at which a new pulse is launched, so the owner of credit can decrement in lockstep.
  assign step = load ? (load_count != '0) : (!pulse && remaining != '0);
  assign done = !pulse && remaining == '0;

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      pulse     <= 1'b0;
      remaining <= '0;
    end else if (load) begin
      pulse     <= (load_count != '0);
      remaining <= (load_count != '0) ? load_count - CW'(1) : '0;
    end else if (pulse) begin
      pulse <= 1'b0;
    end else if (remaining != '0) begin
      pulse     <= 1'b1;
      remaining <= remaining - CW'(1);
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine controller: coin credit, product selection, vend and change return.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int N_PROD     = 2,
  parameter int PRICE      = 9,
  parameter int MAX_CREDIT = 13,
  parameter int CW         = 4
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              ni,
  input  logic              di,
  input  logic              qu,
  input  logic [N_PROD-1:0] sel,
  input  logic              cancel,
  output logic [N_PROD-1:0] give,
  output logic              change,
  output logic              coin_reject,
  output logic [CW-1:0]     credit,
  output logic              busy
);

  localparam int            CW1     = CW + 1;
  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
  localparam logic [CW:0]   MAX_C   = CW1'(MAX_CREDIT);

  state_t            state;
  logic              coin_any;
  logic [CW:0]       coin_val;
  logic [CW:0]       coin_sum;
  logic [N_PROD-1:0] sel_low;
  logic              chg_load;
  logic              chg_step;
  logic              chg_done;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    coin_val = '0;
    if (qu)      coin_val = CW1'(QUARTER);
    else if (di) coin_val = CW1'(DIME);
    else if (ni) coin_val = CW1'(NICKEL);
    coin_any = qu | di | ni;
    coin_sum = {1'b0, credit} + coin_val;
  end

  // Isolate the lowest set request bit.
  assign sel_low = sel & (~sel + N_PROD'(1));

  assign chg_load = !rst && ((state == CREDIT && cancel) || (state == VEND && credit != '0));

  vend_change #(.CW(CW)) u_change (
    .CLK        (CLK),
    .rst        (rst),
    .load       (chg_load),
    .load_count (credit),
    .pulse      (change),
    .step       (chg_step),
    .done       (chg_done)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      state       <= IDLE;
      credit      <= '0;
      give        <= '0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      give        <= '0;
      coin_reject <= 1'b0;
      unique case (state)
        IDLE, CREDIT: begin
          if (cancel && state == CREDIT) begin
            state  <= CHANGE;
            busy   <= 1'b1;
            credit <= credit - CW'(1);
          end else if (coin_any) begin
            if (coin_sum <= MAX_C) begin
              credit <= coin_sum[CW-1:0];
              state  <= CREDIT;
            end else begin
              coin_reject <= 1'b1;
            end
          end else if (sel != '0 && credit >= PRICE_C) begin
            give   <= sel_low;
            credit <= credit - PRICE_C;
            state  <= VEND;
            busy   <= 1'b1;
          end
        end
        VEND: begin
          coin_reject <= coin_any;
          if (credit != '0) begin
            state  <= CHANGE;
            credit <= credit - CW'(1);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        CHANGE: begin
          coin_reject <= coin_any;
          if (chg_step) credit <= credit - CW'(1);
          if (chg_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl with default parameters.
module tb_vend_ctrl;

  localparam int N_PROD     = 2;
  localparam int PRICE      = 9;
  localparam int MAX_CREDIT = 13;
  localparam int CW         = 4;

  logic              CLK = 1'b0;
  logic              rst = 1'b1;
  logic              ni = 1'b0, di = 1'b0, qu = 1'b0, cancel = 1'b0;
  logic [N_PROD-1:0] sel = '0;
  logic [N_PROD-1:0] give;
  logic              change, coin_reject, busy;
  logic [CW-1:0]     credit;

  int n_checks = 0;
  int n_errors = 0;

  vend_ctrl #(
    .N_PROD(N_PROD), .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .CW(CW)
  ) dut (
    .CLK(CLK), .rst(rst), .ni(ni), .di(di), .qu(qu), .sel(sel), .cancel(cancel),
    .give(give), .change(change), .coin_reject(coin_reject), .credit(credit), .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic n, input logic d, input logic q,
                       input logic [N_PROD-1:0] s, input logic c);
    ni = n; di = d; qu = q; sel = s; cancel = c;
    tick();
    ni = 1'b0; di = 1'b0; qu = 1'b0; sel = '0; cancel = 1'b0;
  endtask

  task automatic coin(input int v);
    drive(v == 1, v == 2, v == 5, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [N_PROD-1:0] g, input logic ch,
                            input logic rej, input logic [CW-1:0] cr, input logic bz);
    check({tag, ".give"},   32'(give),        32'(g));
    check({tag, ".change"}, 32'(change),      32'(ch));
    check({tag, ".reject"}, 32'(coin_reject), 32'(rej));
    check({tag, ".credit"}, 32'(credit),      32'(cr));
    check({tag, ".busy"},   32'(busy),        32'(bz));
  endtask

  // Walk through the remaining busy period, counting change pulses and back-to-back highs.
  task automatic run_change(input int budget, output int pulses, output int cycles,
                            output logic spaced);
    logic prev;
    prev   = 1'b0;
    pulses = 0;
    cycles = 0;
    spaced = 1'b1;
    while (busy === 1'b1 && cycles < budget) begin
      if (change === 1'b1) begin
        pulses++;
        if (prev) spaced = 1'b0;
      end
      prev = change;
      cycles++;
      tick();
    end
  endtask

  initial begin
    int   pulses, cycles, quiet;
    logic spaced;

    // Reset with a coin present: the coin must be ignored.
    qu = 1'b1;
    tick();
    qu = 1'b0;
    rst = 1'b0;
    expect_out("reset", 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);

    // Two quarters then product 0: one change nickel.
    coin(5);
    check("q1.credit", 32'(credit), 32'd5);
    coin(5);
    check("q2.credit", 32'(credit), 32'd10);
    drive(0, 0, 0, 2'b01, 0);
    expect_out("vend01", 2'b01, 1'b0, 1'b0, 4'd1, 1'b1);
    tick();
    expect_out("vend01.pulse", 2'b00, 1'b1, 1'b0, 4'd0, 1'b1);
    tick();
    expect_out("vend01.gap", 2'b00, 1'b0, 1'b0, 4'd0, 1'b1);
    tick();
    expect_out("vend01.idle", 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);

    // Exact price, product 1: no change.
    do_reset();
    coin(5); coin(2); coin(1); coin(1);
    check("exact.credit", 32'(credit), 32'd9);
    drive(0, 0, 0, 2'b10, 0);
    expect_out("vend10", 2'b10, 1'b0, 1'b0, 4'd0, 1'b1);
    tick();
    expect_out("vend10.idle", 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);

    // Credit ceiling: overflowing coins are refused.
    do_reset();
    coin(5); coin(5); coin(2);
    check("ceil.credit", 32'(credit), 32'd12);
    coin(5);
    expect_out("ceil.qu", 2'b00, 1'b0, 1'b1, 4'd12, 1'b0);
    coin(2);
    expect_out("ceil.di", 2'b00, 1'b0, 1'b1, 4'd12, 1'b0);
    coin(1);
    expect_out("ceil.ni", 2'b00, 1'b0, 1'b0, 4'd13, 1'b0);
    // A coin with sel at full credit: coin refused, sel ignored.
    drive(1, 0, 0, 2'b01, 0);
    expect_out("ceil.coin_sel", 2'b00, 1'b0, 1'b1, 4'd13, 1'b0);

    // Cancel beats sel: full credit returned as spaced pulses.
    do_reset();
    coin(5); coin(2);
    drive(0, 0, 0, 2'b01, 1);
    expect_out("cancel.first", 2'b00, 1'b1, 1'b0, 4'd6, 1'b1);
    run_change(40, pulses, cycles, spaced);
    check("cancel.pulses", 32'(pulses), 32'd7);
    check("cancel.cycles", 32'(cycles), 32'd14);
    check("cancel.spaced", 32'(spaced), 32'd1);
    expect_out("cancel.idle", 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);

    // Third quarter refused at 10; reach 13, select both products.
    do_reset();
    coin(5); coin(5); coin(5);
    expect_out("q3.reject", 2'b00, 1'b0, 1'b1, 4'd10, 1'b0);
    coin(2); coin(1);
    check("max.credit", 32'(credit), 32'd13);
    drive(0, 0, 0, 2'b11, 0);
    expect_out("vend11", 2'b01, 1'b0, 1'b0, 4'd4, 1'b1);
    tick();
    expect_out("vend11.pulse1", 2'b00, 1'b1, 1'b0, 4'd3, 1'b1);
    coin(1);
    expect_out("vend11.ni_rej", 2'b00, 1'b0, 1'b1, 4'd3, 1'b1);
    run_change(40, pulses, cycles, spaced);
    check("vend11.pulses", 32'(pulses + 1), 32'd4);
    check("vend11.spaced", 32'(spaced), 32'd1);
    expect_out("vend11.idle", 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);

    // Reset after the second change pulse stops the sequence.
    do_reset();
    coin(5); coin(5); coin(2); coin(1);
    drive(0, 0, 0, 2'b11, 0);
    tick();
    tick();
    tick();
    expect_out("rstchg.pulse2", 2'b00, 1'b1, 1'b0, 4'd2, 1'b1);
    do_reset();
    expect_out("rstchg.after", 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
    quiet = 0;
    for (int i = 0; i < 8; i++) begin
      if (change !== 1'b0 || busy !== 1'b0) quiet++;
      tick();
    end
    check("rstchg.quiet", 32'(quiet), 32'd0);

    // Below price sel ignored; same-cycle coin with sel processes only the coin.
    do_reset();
    coin(5);
    drive(0, 0, 0, 2'b01, 0);
    expect_out("lowsel", 2'b00, 1'b0, 1'b0, 4'd5, 1'b0);
    drive(0, 0, 1, 2'b01, 0);
    expect_out("coin_sel", 2'b00, 1'b0, 1'b0, 4'd10, 1'b0);

    // Coin priority and cancel in IDLE.
    do_reset();
    drive(0, 0, 0, 2'b00, 1);
    expect_out("idle_cancel", 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
    drive(1, 1, 1, 2'b00, 0);
    expect_out("prio", 2'b00, 1'b0, 1'b0, 4'd5, 1'b0);
    drive(1, 1, 0, 2'b00, 0);
    expect_out("prio_di", 2'b00, 1'b0, 1'b0, 4'd7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
